// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Segment words are {g,f,e,d,c,b,a} in active-low form (0 = segment lit).
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;

  // Map an active-low segment word onto the pin polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_n, input bit active_low);
    return active_low ? seg_n : ~seg_n;
  endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational hex nibble to 7-segment decoder, active-low output.
// clear_i forces every segment dark regardless of the nibble.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       clear_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_OFF;
    if (!clear_i) begin
      unique case (nibble_i)
        4'h0: seg_n_o = SEG_0;
        4'h1: seg_n_o = SEG_1;
        4'h2: seg_n_o = SEG_2;
        4'h3: seg_n_o = SEG_3;
        4'h4: seg_n_o = SEG_4;
        4'h5: seg_n_o = SEG_5;
        4'h6: seg_n_o = SEG_6;
        4'h7: seg_n_o = SEG_7;
        4'h8: seg_n_o = SEG_8;
        4'h9: seg_n_o = SEG_9;
        4'hA: seg_n_o = SEG_A;
        4'hB: seg_n_o = SEG_B;
        4'hC: seg_n_o = SEG_C;
        4'hD: seg_n_o = SEG_D;
        4'hE: seg_n_o = SEG_E;
        4'hF: seg_n_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit hex display driver with frame-aligned updates,
// leading-zero suppression, per-digit blank/blink and decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned CLK_DIV    = 1000,
  parameter int unsigned BLINK_FRM  = 64,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_mask_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  input  logic                  lz_en_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  upd_pend_o
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FrmW = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRM - 1);

  logic [DivW-1:0]     div_q, div_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [FrmW-1:0]     frm_q, frm_d;
  logic                blink_on_q, blink_on_d;
  logic                upd_pend_q, upd_pend_d;

  logic [4*DIGITS-1:0] pend_val_q, disp_val_q;
  logic [DIGITS-1:0]   pend_dp_q, pend_blank_q, pend_blink_q;
  logic [DIGITS-1:0]   disp_dp_q, disp_blank_q, disp_blink_q;
  logic                pend_lz_q, disp_lz_q;

  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick, frame_end;
  logic [DIGITS-1:0]   lz_dark, an_hot;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_dark, nz_seen;
  logic [6:0]          seg_n;

  assign tick      = (div_q == DivLast);
  assign frame_end = tick && (idx_q == IdxLast);

  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    idx_d      = idx_q;
    frm_d      = frm_q;
    blink_on_d = blink_on_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      if (frm_q == FrmLast) begin
        frm_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
    // A load on the boundary cycle keeps the new word pending for one more frame.
    upd_pend_d = upd_pend_q;
    if (frame_end) upd_pend_d = 1'b0;
    if (load_i)    upd_pend_d = 1'b1;
  end

  // Scan from the top digit down; blanked digits never count as significant.
  always_comb begin
    nz_seen = 1'b0;
    lz_dark = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz_seen    = nz_seen | ((disp_val_q[i*4 +: 4] != 4'd0) & ~disp_blank_q[i]);
      lz_dark[i] = disp_lz_q & ~nz_seen & (i != 0);
    end
  end

  always_comb begin
    cur_nib  = 4'd0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    an_hot   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = disp_val_q[i*4 +: 4];
        cur_dp    = disp_dp_q[i];
        cur_dark  = disp_blank_q[i] | (~blink_on_q & disp_blink_q[i]) | lz_dark[i];
        an_hot[i] = 1'b1;
      end
    end
  end

  seg7_hexdec u_hexdec (
    .nibble_i (cur_nib),
    .clear_i  (cur_dark),
    .seg_n_o  (seg_n)
  );

  // Everything goes dark on the cycle idx moves, so the old segments never ghost.
  always_comb begin
    seg_d = seg_polarity(SEG_OFF, ACTIVE_LOW);
    dp_d  = ACTIVE_LOW;
    an_d  = {DIGITS{ACTIVE_LOW}};
    if (!tick) begin
      seg_d = seg_polarity(seg_n, ACTIVE_LOW);
      dp_d  = (cur_dp & ~cur_dark) ^ ACTIVE_LOW;
      an_d  = ACTIVE_LOW ? ~an_hot : an_hot;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      blink_on_q   <= 1'b1;
      upd_pend_q   <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_blink_q <= '0;
      pend_lz_q    <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      disp_blink_q <= '0;
      disp_lz_q    <= 1'b0;
      seg_q        <= seg_polarity(SEG_OFF, ACTIVE_LOW);
      dp_q         <= ACTIVE_LOW;
      an_q         <= {DIGITS{ACTIVE_LOW}};
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      frm_q      <= frm_d;
      blink_on_q <= blink_on_d;
      upd_pend_q <= upd_pend_d;
      if (load_i) begin
        pend_val_q   <= value_i;
        pend_dp_q    <= dp_i;
        pend_blank_q <= blank_mask_i;
        pend_blink_q <= blink_mask_i;
        pend_lz_q    <= lz_en_i;
      end
      if (frame_end && upd_pend_q) begin
        disp_val_q   <= pend_val_q;
        disp_dp_q    <= pend_dp_q;
        disp_blank_q <= pend_blank_q;
        disp_blink_q <= pend_blink_q;
        disp_lz_q    <= pend_lz_q;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign an_o       = an_q;
  assign upd_pend_o = upd_pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues expected digit slots,
// a monitor pops one entry at the start of every lit digit slot.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned BLINK_FRM = 2;
  localparam bit          ACTIVE_LOW = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        upd_pend;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS     (DIGITS),
    .CLK_DIV    (CLK_DIV),
    .BLINK_FRM  (BLINK_FRM),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .value_i      (value),
    .dp_i         (dp_in),
    .blank_mask_i (blank_mask),
    .blink_mask_i (blink_mask),
    .lz_en_i      (lz_en),
    .seg_o        (seg),
    .dp_o         (dp),
    .an_o         (an),
    .upd_pend_o   (upd_pend)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // dpn holds the expected active-low dp pin per digit.
  task automatic push_frame(input int tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    exp_t e;
    e.tag = tag; e.an = 4'hE; e.seg = s0; e.dp = dpn[0]; exp_q.push_back(e);
    e.tag = tag; e.an = 4'hD; e.seg = s1; e.dp = dpn[1]; exp_q.push_back(e);
    e.tag = tag; e.an = 4'hB; e.seg = s2; e.dp = dpn[2]; exp_q.push_back(e);
    e.tag = tag; e.an = 4'h7; e.seg = s3; e.dp = dpn[3]; exp_q.push_back(e);
  endtask

  // Returns on the first cycle of a fresh slot showing v.
  task automatic wait_an(input logic [3:0] v);
    int n = 0;
    while (an === v && n < 100) begin @(negedge clk); n++; end
    while (an !== v && n < 100) begin @(negedge clk); n++; end
    check("wait_an", {28'h0, an}, {28'h0, v});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic frame_test(input int tag, input logic [15:0] v, input logic [3:0] dpv,
                            input logic [3:0] blk, input logic lz,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
    drain();
    wait_an(4'h7);
    @(negedge clk);
    push_frame(tag, s0, s1, s2, s3, dpn);
    value = v; dp_in = dpv; blank_mask = blk; blink_mask = 4'h0; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pend_set", upd_pend, 1);
    @(negedge clk);
    check("pend_clr_at_wrap", upd_pend, 0);
  endtask

  // Monitor: compares each lit slot against the queue and checks the 1-cycle gap.
  initial begin
    logic [3:0] prev_an;
    int gap;
    exp_t e;
    prev_an = 4'hF;
    gap = -100;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap = -100;
      end else if (an === 4'hF) begin
        gap++;
      end else if (prev_an === 4'hF) begin
        if (gap > 0) check("an_gap_len", gap, 1);
        gap = 0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
            failures++;
            $display("FAIL slot tag=%0d: an=%h seg=%b dp=%b required an=%h seg=%b dp=%b",
                     e.tag, an, seg, dp, e.an, e.seg, e.dp);
          end
        end
      end
      prev_an = an;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first scan walk over the blank display.
    push_frame(0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_an", an, 4'hF);
    check("rst_pend", upd_pend, 0);
    rst = 1'b0;

    frame_test(1, 16'h12AF, 4'h0, 4'h0, 1'b0,
               7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001, 4'hF);
    frame_test(2, 16'h0005, 4'h0, 4'h0, 1'b1,
               7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    frame_test(3, 16'h0000, 4'h0, 4'h0, 1'b1,
               7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    frame_test(4, 16'h1005, 4'b0110, 4'b1000, 1'b1,
               7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    frame_test(5, 16'h3C0E, 4'b1010, 4'h0, 1'b1,
               7'b0000110, 7'b1000000, 7'b1000110, 7'b0110000, 4'b0101);

    // Two loads inside one frame: only the last is ever shown.
    drain();
    wait_an(4'h7);
    @(negedge clk);
    push_frame(6, 7'b0000110, 7'b1000000, 7'b1000110, 7'b0110000, 4'b0101);
    push_frame(6, 7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100, 4'hF);
    wait_an(4'hE);
    value = 16'h1111; dp_in = 4'h0; blank_mask = 4'h0; lz_en = 1'b0; load = 1'b1;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    check("pend_two_loads", upd_pend, 1);

    // Load on the boundary tick: old pending commits, new one waits a frame.
    drain();
    wait_an(4'h7);
    value = 16'h4567; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame(7, 7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001, 4'hF);
    push_frame(8, 7'b0100001, 7'b0000011, 7'b0010000, 7'b0000000, 4'hF);
    @(negedge clk);
    value = 16'h89BD; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pend_after_coincident", upd_pend, 1);
    drain();
    check("pend_after_second_commit", upd_pend, 0);

    // Blink from a fresh reset: phase on for frames 0-1, off 2-3, on 4-5, off 6.
    @(negedge clk);
    rst = 1'b1;
    push_frame(9, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    push_frame(10, 7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'hE);
    push_frame(11, 7'h7F, 7'b1000000, 7'b1000000, 7'b1000000, 4'hF);
    push_frame(12, 7'h7F, 7'b1000000, 7'b1000000, 7'b1000000, 4'hF);
    push_frame(13, 7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'hE);
    push_frame(14, 7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'hE);
    push_frame(15, 7'h7F, 7'b1000000, 7'b1000000, 7'b1000000, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    value = 16'h0008; dp_in = 4'b0001; blank_mask = 4'h0; blink_mask = 4'b0001; lz_en = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    drain();

    // Reset mid-frame while a word is pending: dark on the next cycle.
    wait_an(4'hD);
    value = 16'hABCD; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pend_before_rst", upd_pend, 1);
    check("an_before_rst", an, 4'hD);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp", dp, 1);
    check("midrst_an", an, 4'hF);
    check("midrst_pend", upd_pend, 0);
    rst = 1'b0;
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
